// File: rtl/fmap_bram.sv
`default_nettype none
// ============================================================================
// Module   : fmap_bram
// Purpose  : Dual-port feature-map buffer holding CHANNELS*IMG_SIZE*IMG_SIZE
//            signed words. Port A is a pipelined synchronous read and Port B
//            is a synchronous write. A built-in zero-fill engine clears the
//            whole array on request.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        - clock
//   reset      - synchronous, active-high reset
//   r_addr     - Port A read address
//   r_en       - Port A read enable
//   r_q        - Port A read data, valid READ_LATENCY-1 edges after the
//                sample edge; holds its value between valid words
//   w_addr     - Port B address
//   w_en       - Port B enable
//   w_we       - Port B write enable (write when w_en && w_we)
//   w_d        - Port B write data
//   clear      - single-cycle zero-fill request
//   busy       - high while the zero-fill runs
//   clear_done - one-cycle pulse when the zero-fill completes
//   oor        - sticky out-of-range address flag (cleared by reset only)
//   collision  - (FMAP_BRAM_COLLISION_CHECK_EN only) sticky flag for a
//                same-edge read/write to the same in-range address
//
// Optional feature macro: FMAP_BRAM_COLLISION_CHECK_EN
// ============================================================================
module fmap_bram #(
    parameter int DATA_WIDTH   = 16,
    parameter int CHANNELS     = 8,
    parameter int IMG_SIZE     = 28,
    parameter int READ_LATENCY = 1,
    localparam int N           = CHANNELS * IMG_SIZE * IMG_SIZE,
    localparam int AW          = (N <= 1) ? 1 : $clog2(N)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [AW-1:0]                r_addr,
    input  logic                         r_en,
    output logic signed [DATA_WIDTH-1:0] r_q,
    input  logic [AW-1:0]                w_addr,
    input  logic                         w_en,
    input  logic                         w_we,
    input  logic signed [DATA_WIDTH-1:0] w_d,
    input  logic                         clear,
    output logic                         busy,
    output logic                         clear_done,
    output logic                         oor
`ifdef FMAP_BRAM_COLLISION_CHECK_EN
    ,
    output logic                         collision
`endif
);

    // One extra bit so that N itself is representable when N is a power of 2.
    localparam logic [AW:0]   N_EXT     = (AW + 1)'(N);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                        state_q;
    logic [AW-1:0]                 fill_cnt_q;
    logic                          busy_q;
    logic                          clear_done_q;
    logic                          oor_q;

    logic signed [DATA_WIDTH-1:0]  mem [0:N-1];

    logic                          r_in_range;
    logic                          w_in_range;
    logic                          ext_wr;
    logic                          mem_we;
    logic [AW-1:0]                 mem_waddr;
    logic signed [DATA_WIDTH-1:0]  mem_wdata;
    logic signed [DATA_WIDTH-1:0]  rd_word_d;

    assign r_in_range = ({1'b0, r_addr} < N_EXT);
    assign w_in_range = ({1'b0, w_addr} < N_EXT);

    // External writes are locked out for the whole fill; the fill engine
    // owns the single write port while busy.
    assign ext_wr    = w_en && w_we && w_in_range && !busy_q;
    assign mem_we    = !reset && (busy_q || ext_wr);
    assign mem_waddr = busy_q ? fill_cnt_q : w_addr;
    assign mem_wdata = busy_q ? '0 : w_d;

    // ------------------------------------------------------------------
    // Storage (no reset so it maps onto block RAM)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Out-of-range reads return 0 rather than indexing past the array.
    // The read is registered in the same edge as any write, so a
    // same-address access returns the old contents (read-first).
    always_comb begin
        rd_word_d = '0;
        if (r_in_range) begin
            rd_word_d = mem[r_addr];
        end
    end

    // ------------------------------------------------------------------
    // Port A read pipeline
    // ------------------------------------------------------------------
    generate
        if (READ_LATENCY <= 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_q <= '0;
                end else if (r_en) begin
                    r_q <= rd_word_d;
                end
            end
        end else begin : g_latn
            // READ_LATENCY-1 internal stages, then r_q as the final stage.
            localparam int STAGES = READ_LATENCY - 1;

            logic signed [DATA_WIDTH-1:0] pipe_data_q [STAGES];
            logic [STAGES-1:0]            pipe_vld_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < STAGES; i++) begin
                        pipe_data_q[i] <= '0;
                    end
                    pipe_vld_q <= '0;
                    r_q        <= '0;
                end else begin
                    pipe_data_q[0] <= rd_word_d;
                    pipe_vld_q[0]  <= r_en;
                    for (int i = 1; i < STAGES; i++) begin
                        pipe_data_q[i] <= pipe_data_q[i-1];
                        pipe_vld_q[i]  <= pipe_vld_q[i-1];
                    end
                    // r_q only moves when a valid word leaves the pipe.
                    if (pipe_vld_q[STAGES-1]) begin
                        r_q <= pipe_data_q[STAGES-1];
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Zero-fill FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fill_cnt_q   <= '0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    clear_done_q <= 1'b0;
                    if (clear) begin
                        state_q    <= S_FILL;
                        fill_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                S_FILL: begin
                    // The write for the last address happens on this edge.
                    if (fill_cnt_q == LAST_ADDR) begin
                        state_q      <= S_DONE;
                        busy_q       <= 1'b0;
                        clear_done_q <= 1'b1;
                    end else begin
                        fill_cnt_q <= fill_cnt_q + AW'(1);
                    end
                end
                S_DONE: begin
                    clear_done_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                    clear_done_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky out-of-range flag. Writes ignored during a fill never count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            oor_q <= 1'b0;
        end else if ((r_en && !r_in_range) ||
                     (w_en && w_we && !w_in_range && !busy_q)) begin
            oor_q <= 1'b1;
        end
    end

    assign busy       = busy_q;
    assign clear_done = clear_done_q;
    assign oor        = oor_q;

`ifdef FMAP_BRAM_COLLISION_CHECK_EN
    logic collision_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            collision_q <= 1'b0;
        end else if (r_en && w_en && w_we && (r_addr == w_addr) &&
                     r_in_range && w_in_range && !busy_q) begin
            collision_q <= 1'b1;
`ifndef SYNTHESIS
            $warning("fmap_bram: read/write collision at address %0d", r_addr);
`endif
        end
    end

    assign collision = collision_q;
`endif

endmodule
`default_nettype wire
